// File: rtl/pong_pkg.sv
// Shared constants for the Pong PS/2 front end: scan codes, game keys and
// the receive state machine encoding.
package pong_pkg;

    // Protocol prefixes and device responses
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_EE = 8'hEE;

    // Make codes the game controller reacts to
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_J     = 8'h3B;
    localparam logic [7:0] KEY_L     = 8'h4B;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_G     = 8'h34;
    localparam logic [7:0] KEY_B     = 8'h32;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Bytes the keyboard sends as command replies rather than key codes
    function automatic logic is_device_response(input logic [7:0] b);
        return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) ||
               (b == SC_EE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce filter: the output only
// follows the synchronized input once it has held a new level for
// FILTER_LEN consecutive samples. Idle level of a PS/2 line is high.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic line_out
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchronizer and filter state; lines reset to idle-high so no edge
    // is seen when reset releases
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive samples that disagree with the filtered level
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserializes device-to-host frames, strips break
// and extended prefixes, and presents each make code on tasta with a long
// done strobe so a per-pixel sampler cannot miss it.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DONE_HOLD      = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tasta,
    output logic       done,
    output logic       ext,
    output logic       parity_err,
    output logic       frame_err
);
    import pong_pkg::*;

    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    logic clk_filt;
    logic data_filt;
    logic edge_flag;

    rx_state_t   state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic        break_pend_q, break_pend_d;
    logic        ext_pend_q, ext_pend_d;
    logic        clk_prev_q;
    logic [7:0]  tasta_q, tasta_d;
    logic        ext_q, ext_d;
    logic        done_q, done_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock    (clock),
        .reset    (reset),
        .line_in  (ps2_clk),
        .line_out (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clock    (clock),
        .reset    (reset),
        .line_in  (ps2_data),
        .line_out (data_filt)
    );

    // Falling edge of the filtered clock, high for exactly one cycle
    assign edge_flag = clk_prev_q & ~clk_filt;

    // State register for the receiver, prefix flags and output strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= RX_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_q         <= '0;
            hold_q       <= '0;
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            clk_prev_q   <= 1'b1;
            tasta_q      <= '0;
            ext_q        <= 1'b0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_q         <= to_d;
            hold_q       <= hold_d;
            break_pend_q <= break_pend_d;
            ext_pend_q   <= ext_pend_d;
            clk_prev_q   <= clk_filt;
            tasta_q      <= tasta_d;
            ext_q        <= ext_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Frame FSM, byte classification, done hold and mid-frame timeout
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        hold_d       = hold_q;
        break_pend_d = break_pend_q;
        ext_pend_d   = ext_pend_q;
        tasta_d      = tasta_q;
        ext_d        = ext_q;
        done_d       = done_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        // Done stays high until the hold counter has run down to zero
        if (done_q) begin
            if (hold_q == '0) begin
                done_d = 1'b0;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end

        // Timeout only runs while a frame is in progress
        if (state_q == RX_IDLE || edge_flag) begin
            to_d = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (edge_flag && !data_filt) begin
                    state_d  = RX_DATA;
                    bitcnt_d = '0;
                end
            end
            RX_DATA: begin
                if (edge_flag) begin
                    shift_d  = {data_filt, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (edge_flag) begin
                    parity_d = data_filt;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (edge_flag) begin
                    state_d = RX_IDLE;
                    if (!data_filt) begin
                        frame_err_d = 1'b1;
                    end else if (!(^{shift_q, parity_q})) begin
                        parity_err_d = 1'b1;
                        break_pend_d = 1'b0;
                        ext_pend_d   = 1'b0;
                    end else if (shift_q == SC_F0) begin
                        break_pend_d = 1'b1;
                    end else if (shift_q == SC_E0) begin
                        ext_pend_d = 1'b1;
                    end else if (is_device_response(shift_q)) begin
                        // command replies carry no key information
                    end else if (break_pend_q) begin
                        break_pend_d = 1'b0;
                        ext_pend_d   = 1'b0;
                    end else begin
                        tasta_d    = shift_q;
                        ext_d      = ext_pend_q;
                        ext_pend_d = 1'b0;
                        done_d     = 1'b1;
                        hold_d     = HOLD_W'(DONE_HOLD - 1);
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Abandon a stalled frame; prefix flags survive the abort
        if (state_q != RX_IDLE && !edge_flag &&
            to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = RX_IDLE;
            frame_err_d = 1'b1;
            to_d        = '0;
        end
    end

    assign tasta      = tasta_q;
    assign done       = done_q;
    assign ext        = ext_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed key sequences followed by a random
// byte stream, checked against a frame-level model of the scan-code rules.
module tb_ps2_scancode_rx;
    import pong_pkg::*;

    localparam int H       = 20;    // half PS/2 bit period in clocks
    localparam int TIMEOUT = 5000;
    localparam int HOLD    = 1024;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] tasta;
    logic       done, ext, parity_err, frame_err;

    ps2_scancode_rx dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .tasta      (tasta),
        .done       (done),
        .ext        (ext),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #20 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: pulse counts, pulse widths and done run lengths
    logic done_prev = 1'b0, perr_prev = 1'b0, ferr_prev = 1'b0;
    int   done_run = 0, last_run = 0, done_rises = 0;
    int   perr_cnt = 0, ferr_cnt = 0, wide_cnt = 0, both_cnt = 0;

    always @(negedge clock) begin
        done_prev <= done;
        perr_prev <= parity_err;
        ferr_prev <= frame_err;
        if (done) begin
            done_run <= done_run + 1;
            if (!done_prev) done_rises <= done_rises + 1;
        end else begin
            if (done_prev) last_run <= done_run;
            done_run <= 0;
        end
        if (parity_err && !perr_prev) perr_cnt <= perr_cnt + 1;
        if (frame_err && !ferr_prev)  ferr_cnt <= ferr_cnt + 1;
        if ((parity_err && perr_prev) || (frame_err && ferr_prev)) wide_cnt <= wide_cnt + 1;
        if (parity_err && frame_err) both_cnt <= both_cnt + 1;
    end

    // Reference model state
    logic [7:0] m_tasta = 8'h00;
    logic       m_ext = 1'b0, m_brk = 1'b0, m_extp = 1'b0, m_acc = 1'b0;
    int         m_perr = 0, m_ferr = 0;
    int         last_acc_cyc = -100000;
    int         stop_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive the first nbits bits of a device-to-host frame onto the pins
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        wait_cyc(H);
        ps2_data = 1'b1;
    endtask

    // Scan-code rules applied to one whole received frame
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit complete);
        m_acc = 1'b0;
        if (!complete || bad_stop) begin
            m_ferr++;
        end else if (bad_par) begin
            m_perr++;
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_extp = 1'b1;
        end else if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
                     b == 8'h00 || b == 8'hFF) begin
            m_acc = 1'b0;
        end else if (m_brk) begin
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else begin
            m_tasta = b;
            m_ext   = m_extp;
            m_extp  = 1'b0;
            m_acc   = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                         input int nbits, input int gap);
        send_bits(b, bad_par, bad_stop, nbits);
        model_frame(b, bad_par, bad_stop, nbits == 11);
        if (m_acc) last_acc_cyc = stop_cyc;
        if (nbits < 11) wait_cyc(TIMEOUT + 300);
        else wait_cyc(gap);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":tasta"}, {24'h0, tasta}, {24'h0, m_tasta});
        chk({tag, ":ext"}, {31'h0, ext}, {31'h0, m_ext});
        chk({tag, ":perr_cnt"}, perr_cnt, m_perr);
        chk({tag, ":ferr_cnt"}, ferr_cnt, m_ferr);
        if (m_acc) chk({tag, ":done_hi"}, {31'h0, done}, 32'h1);
        else if (cyc - last_acc_cyc > HOLD + 80) chk({tag, ":done_lo"}, {31'h0, done}, 32'h0);
    endtask

    logic [7:0] keys [11];
    logic [7:0] rsp  [6];
    int rises0, t1;

    initial begin
        keys = '{KEY_SPACE, KEY_ESC, KEY_A, KEY_D, KEY_J, KEY_L, KEY_1, KEY_2, KEY_R, KEY_G, KEY_B};
        rsp  = '{SC_AA, SC_FA, SC_FE, SC_EE, 8'h00, 8'hFF};

        // Reset state
        wait_cyc(5);
        chk("rst:tasta", {24'h0, tasta}, 32'h0);
        chk("rst:done", {31'h0, done}, 32'h0);
        chk("rst:ext", {31'h0, ext}, 32'h0);
        chk("rst:perr", {31'h0, parity_err}, 32'h0);
        chk("rst:ferr", {31'h0, frame_err}, 32'h0);
        reset = 1'b1;
        wait_cyc(20);

        // Single make: exact done width
        frame(KEY_SPACE, 0, 0, 11, 30);
        check_state("space");
        wait_cyc(HOLD + 100);
        chk("space:done_len", last_run, HOLD);
        chk("space:done_off", {31'h0, done}, 32'h0);

        // Press and release A: one done pulse
        rises0 = done_rises;
        frame(KEY_A, 0, 0, 11, 30);
        frame(SC_F0, 0, 0, 11, 30);
        frame(KEY_A, 0, 0, 11, 30);
        check_state("a_rel");
        chk("a_rel:rises", done_rises - rises0, 1);
        wait_cyc(HOLD + 100);

        // Extended make then extended release
        rises0 = done_rises;
        frame(SC_E0, 0, 0, 11, 30);
        frame(8'h75, 0, 0, 11, 30);
        check_state("ext_make");
        frame(SC_E0, 0, 0, 11, 30);
        frame(SC_F0, 0, 0, 11, 30);
        frame(8'h75, 0, 0, 11, 30);
        check_state("ext_rel");
        chk("ext_rel:rises", done_rises - rises0, 1);
        wait_cyc(HOLD + 100);

        // Parity error then clean retry
        frame(KEY_D, 1, 0, 11, 30);
        check_state("par_bad");
        frame(KEY_D, 0, 0, 11, 30);
        check_state("par_retry");
        wait_cyc(HOLD + 100);

        // Clock stalls mid-frame, then a clean ESC
        frame(KEY_ESC, 0, 0, 5, 30);
        check_state("timeout");
        frame(KEY_ESC, 0, 0, 11, 30);
        check_state("after_to");
        wait_cyc(HOLD + 100);

        // Two makes close together: done stays high without a gap
        rises0 = done_rises;
        frame(KEY_L, 0, 0, 11, 60);
        t1 = stop_cyc;
        frame(KEY_J, 0, 0, 11, 30);
        check_state("retrig");
        wait_cyc(HOLD + 100);
        chk("retrig:done_len", last_run, (stop_cyc - t1) + HOLD);
        chk("retrig:rises", done_rises - rises0, 1);

        // Short glitch on the clock line with data low must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(30);
        frame(KEY_R, 0, 0, 11, 30);
        check_state("glitch");

        // Random byte stream
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)       b = keys[$urandom_range(0, 10)];
            else if (r == 4) b = SC_F0;
            else if (r == 5) b = SC_E0;
            else if (r == 6) b = rsp[$urandom_range(0, 5)];
            else             b = 8'($urandom);
            frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 11, 30);
            check_state($sformatf("rnd%0d", n));
        end

        // Reset in the middle of a frame clears everything
        frame(KEY_G, 0, 0, 11, 30);
        send_bits(KEY_B, 0, 0, 5);
        reset = 1'b0;
        wait_cyc(3);
        chk("midrst:tasta", {24'h0, tasta}, 32'h0);
        chk("midrst:done", {31'h0, done}, 32'h0);
        chk("midrst:ext", {31'h0, ext}, 32'h0);
        m_tasta = 8'h00;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_extp  = 1'b0;
        reset   = 1'b1;
        wait_cyc(30);
        frame(KEY_B, 0, 0, 11, 30);
        check_state("after_rst");

        chk("pulse_width", wide_cnt, 0);
        chk("err_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Receives device-to-host PS/2 keyboard frames and deserializes them into scan codes for the Pong game controller.
- Strips break (release) and extended prefixes, so one key press produces exactly one make code.
- Drives tasta/done with timing that the game controller's per-pixel sampling cannot miss.
- Sits between the board PS/2 pins and game_FSM, in the 25 MHz pixel clock domain.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before a filtered PS/2 line changes level
TIMEOUT_CYCLES, 5000, clock cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted (200 us at 25 MHz)
DONE_HOLD, 1024, cycles done stays high after a make code; must exceed one VGA line (800 cycles)

Ports:
clock  input  1  system/pixel clock
reset  input  1  reset, asynchronous, active-low
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clock
ps2_data  input  1  raw PS/2 data pin, asynchronous to clock
tasta  output  8  last accepted make code; stable until the next accepted code
done  output  1  high for DONE_HOLD cycles after each accepted make code
ext  output  1  1 if the current tasta was preceded by an E0 prefix
parity_err  output  1  one-cycle pulse when a frame fails odd parity
frame_err  output  1  one-cycle pulse on bad stop bit or timeout

Behaviour:
- Reset (async, low): tasta=0, done=0, ext=0, parity_err=0, frame_err=0; FSM=IDLE; bit counter, hold counter, timeout counter and prefix flags all cleared. Reset asserted mid-frame discards the partial frame.
- Input path: each pin passes through a 2-FF synchronizer, then the filter. The filtered level changes only after FILTER_LEN equal samples. An edge is a filtered ps2_clk 1->0 transition, flagged for exactly one cycle.
- Frame format: 11 bits, all sampled on edges. Start bit 0, then D0..D7 LSB first, then odd parity, then stop bit 1.
- FSM states:
  - IDLE: on edge with data=0 -> DATA, bitcnt=0. On edge with data=1, ignore and stay in IDLE.
  - DATA: on each edge, shift data into bit 7 of shift register (right shift). After the 8th bit -> PARITY.
  - PARITY: on edge, capture the parity bit -> STOP.
  - STOP: on edge, evaluate the byte -> IDLE.
- Timeout: the counter resets on every edge and counts while not in IDLE. On reaching TIMEOUT_CYCLES: frame_err pulses, FSM -> IDLE, byte discarded, prefix flags unchanged.
- STOP evaluation, in priority order:
  1. stop bit = 0: frame_err pulse; discard.
  2. XOR of 8 data bits and parity bit = 0: parity_err pulse; discard; clear break_pend and ext_pend.
  3. Byte = F0: set break_pend.
  4. Byte = E0: set ext_pend.
  5. Byte is AA, FA, FE, EE, 00 or FF (device responses): discard; flags unchanged.
  6. Any other byte with break_pend=1: discard (release); clear both flags.
  7. Any other byte with break_pend=0: accept (make).
- Accept, registered at the STOP edge, visible the next cycle: tasta<=byte, ext<=ext_pend, ext_pend<=0, done<=1, hold counter<=DONE_HOLD-1.
- Done hold: the counter decrements while done=1; done<=0 when it reaches 0. Total high time is exactly DONE_HOLD cycles.
- New accept while done=1: tasta/ext update, counter reloads, done stays high with no low gap.
- Prefix orders E0 F0 xx and F0 E0 xx are both handled as an extended release and discarded.
- Typematic repeat make codes are accepted as normal makes; each one retriggers done.
- Latency: pin edge -> edge flag is 2 + FILTER_LEN cycles; stop-bit edge -> done high is 1 cycle.
- Error pulses are exactly one cycle wide. A parity error and a frame error cannot occur on the same frame.

Decomposition:
- Shared package pong_pkg:
  - scan-code constants: F0, E0, AA, FA, FE, EE
  - game key codes: SPACE 29, ESC 76, A 1C, D 23, J 3B, L 4B, 1 16, 2 1E, R 2D, G 34, B 32
  - rx state encoding
- Sub-module ps2_line_filter: synchronizer plus FILTER_LEN debounce, parameterized on FILTER_LEN. Instantiated once for ps2_clk and once for ps2_data.

Test Plan:
- Make 29 (SPACE), 80 us bit period -> tasta=29, ext=0, done high for exactly 1024 cycles, no error pulses.
- Sequence 1C, F0, 1C (press/release A) -> one done pulse, tasta=1C; tasta unchanged after the release.
- Sequence E0 75 then E0 F0 75 -> tasta=75 with ext=1 and one done pulse; the release produces nothing.
- Frame with data 23 and parity bit flipped -> parity_err one-cycle pulse; tasta and done unchanged; a following clean 23 is accepted.
- Clock line stops after 5 bits for more than 5000 cycles -> frame_err pulse, FSM back in IDLE; the next clean frame 76 is accepted.
- Two makes 4B, 3B spaced 500 cycles apart -> done stays high continuously until 1024 cycles after the second; tasta=3B. A 3-cycle glitch on ps2_clk produces no edge. Reset asserted mid-frame -> all outputs 0.
